// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state, grant and abort-data constants for the memory port arbiter
// FSM encodings are plain logic constants so older tools can consume the package.
package arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_WAIT = 2'd1;
  localparam logic [1:0] ST_DM_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/arb_wait_timer.sv
// rtl/arb_wait_timer.sv - wait-cycle counter with terminal flag for the arbiter watchdog
// Loads zero while clr is high, counts while en is high, and parks at TIMEOUT.
module arb_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a shared single-port memory with watchdog
// Optional ARB_PERF_CNT_EN adds completed-transaction and stall-cycle counters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              timeout_err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_dm_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              timeout_err_q, timeout_err_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              wait_expired;
  logic              in_wait;
  logic              gnt_sel;
  logic [DATA_W-1:0] resp_data;

  assign in_wait   = (state_q == ST_IF_WAIT) || (state_q == ST_DM_WAIT);
  assign gnt_sel   = (state_q == ST_DM_WAIT) ? GNT_DM : GNT_IF;
  assign resp_data = mem_ack ? mem_rdata : DATA_W'(TIMEOUT_DATA);

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .Clk     (Clk),
    .Rst     (Rst),
    .clr     (state_q == ST_IDLE),
    .en      (in_wait),
    .expired (wait_expired)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    if_ready_d    = 1'b0;
    dm_ready_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    starve_cnt_d  = starve_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // DM has priority; IF jumps ahead once after STARVE_LIMIT DM grants it sat through
        if (dm_req && !(if_req && starve_cnt_q == SW'(STARVE_LIMIT))) begin
          state_d     = ST_DM_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (if_req) begin
          state_d      = ST_IF_WAIT;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          starve_cnt_d = '0;
        end
      end
      ST_IF_WAIT, ST_DM_WAIT: begin
        if (mem_ack || wait_expired) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (!mem_ack) begin
            timeout_err_d = 1'b1;
          end
          if (gnt_sel == GNT_IF) begin
            if_rdata_d = resp_data;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              dm_rdata_d = resp_data;
            end
            dm_ready_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      if_ready_q    <= 1'b0;
      dm_ready_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      starve_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      if_ready_q    <= if_ready_d;
      dm_ready_q    <= dm_ready_d;
      timeout_err_q <= timeout_err_d;
      starve_cnt_q  <= starve_cnt_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_ready    = if_ready_q;
  assign dm_ready    = dm_ready_q;
  assign timeout_err = timeout_err_q;
  assign stall_if    = if_req & ~if_ready_q;
  assign stall_mem   = dm_req & ~dm_ready_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_cnt_q, perf_if_cnt_d;
  logic [31:0] perf_dm_cnt_q, perf_dm_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_if_cnt_d    = perf_if_cnt_q + {31'd0, if_ready_q};
    perf_dm_cnt_d    = perf_dm_cnt_q + {31'd0, dm_ready_q};
    perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, stall_if | stall_mem};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_if_cnt_q    <= '0;
      perf_dm_cnt_q    <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_if_cnt_q    <= perf_if_cnt_d;
      perf_dm_cnt_q    <= perf_dm_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_if_cnt    = perf_if_cnt_q;
  assign perf_dm_cnt    = perf_dm_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TMO = 15;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_cnt;
  logic [31:0] perf_dm_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int ready_seen = 0;
  int stray_req = 0;
  int stray_done = 0;
  int mem_delay = 0;
  bit mem_hang = 1'b0;

  gnt_t        exp_gnt[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_cnt(perf_if_cnt), .perf_dm_cnt(perf_dm_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial forever #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h40) return 32'h2002000A;
    return (a * 32'd3) ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks mem_delay cycles after mem_req rises, or injects stray acks
  initial begin
    int mcnt;
    mcnt = 0;
    forever begin
      @(posedge Clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        mcnt = 0;
      end else if (stray_req != stray_done) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        stray_done++;
      end else if (!mem_req) begin
        mcnt = 0;
      end else if (!mem_hang) begin
        if (mcnt >= mem_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_f(mem_addr);
        end else begin
          mcnt++;
        end
      end
    end
  end

  // Scoreboard: grants and ready pulses pop the expected queues
  initial begin
    logic mreq_prev;
    gnt_t g;
    logic [31:0] e;
    mreq_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (mem_req && !mreq_prev) begin
        if (exp_gnt.size() == 0) begin
          check("gnt_extra", 32'd1, 32'd0);
        end else begin
          g = exp_gnt.pop_front();
          check("gnt_addr", mem_addr, g.addr);
          check("gnt_we", {31'd0, mem_we}, {31'd0, g.we});
          if (g.we) check("gnt_wdata", mem_wdata, g.wdata);
        end
      end
      mreq_prev = mem_req;
      if (if_ready) begin
        ready_seen++;
        check("stall_if_at_ready", {31'd0, stall_if}, 32'd0);
        if (exp_if.size() == 0) check("if_ready_extra", 32'd1, 32'd0);
        else begin e = exp_if.pop_front(); check("if_rdata", if_rdata, e); end
      end
      if (dm_ready) begin
        ready_seen++;
        check("stall_mem_at_ready", {31'd0, stall_mem}, 32'd0);
        if (exp_dm.size() == 0) check("dm_ready_extra", 32'd1, 32'd0);
        else begin e = exp_dm.pop_front(); check("dm_rdata", dm_rdata, e); end
      end
    end
  end

  task automatic wait_ready(input bit is_dm, output int lat, output int req_cyc, output int if_lo);
    lat = 0; req_cyc = 0; if_lo = 0;
    forever begin
      @(negedge Clk);
      if (is_dm ? dm_ready : if_ready) break;
      if (mem_req) req_cyc++;
      if (if_req && !stall_if) if_lo++;
      lat++;
      if (lat > 100) begin
        if (is_dm) check("dm_ready_timeout", 32'd0, 32'd1);
        else check("if_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat, rc, lo, base;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", if_rdata | dm_rdata | mem_wdata, 32'd0);
    check("rst_flags", {28'd0, if_ready, dm_ready, timeout_err, mem_we}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    base = ready_seen;
    stray_req++;
    repeat (4) @(posedge Clk); #1;
    check("idle_ack_no_ready", ready_seen, base);
    check("idle_ack_no_req", {31'd0, mem_req}, 32'd0);

    mem_delay = 3;
    exp_gnt.push_back('{1'b0, 32'h40, 32'h0});
    exp_if.push_back(32'h2002000A);
    if_addr = 32'h40; if_req = 1'b1;
    wait_ready(1'b0, lat, rc, lo);
    if_req = 1'b0;
    check("fetch_latency", lat, 32'd5);
    @(negedge Clk);
    check("stall_if_after", {31'd0, stall_if}, 32'd0);
    @(posedge Clk); #1;

    mem_delay = 0;
    exp_gnt.push_back('{1'b0, 32'h10, 32'h0});
    exp_dm.push_back(mem_f(32'h10));
    dm_we = 1'b0; dm_addr = 32'h10; dm_req = 1'b1;
    wait_ready(1'b1, lat, rc, lo);
    dm_req = 1'b0;
    check("min_latency", lat, 32'd2);

    mem_delay = 1;
    exp_gnt.push_back('{1'b0, 32'h100, 32'h0});
    exp_gnt.push_back('{1'b0, 32'h80, 32'h0});
    exp_dm.push_back(mem_f(32'h100));
    exp_if.push_back(mem_f(32'h80));
    if_addr = 32'h80; if_req = 1'b1;
    dm_addr = 32'h100; dm_req = 1'b1;
    wait_ready(1'b1, lat, rc, lo);
    dm_req = 1'b0;
    check("stall_if_during_dm", lo, 32'd0);
    wait_ready(1'b0, lat, rc, lo);
    if_req = 1'b0;

    mem_delay = 2;
    for (int k = 0; k < 4; k++) exp_gnt.push_back('{1'b1, 32'h200 + 32'(4 * k), 32'hC0DE0000 + 32'(k)});
    exp_gnt.push_back('{1'b0, 32'h300, 32'h0});
    exp_gnt.push_back('{1'b1, 32'h210, 32'hC0DE0004});
    for (int k = 0; k < 5; k++) exp_dm.push_back(mem_f(32'h100));
    exp_if.push_back(mem_f(32'h300));
    fork
      begin
        int l1, r1, s1;
        for (int k = 0; k < 5; k++) begin
          dm_we = 1'b1; dm_addr = 32'h200 + 32'(4 * k); dm_wdata = 32'hC0DE0000 + 32'(k);
          dm_req = 1'b1;
          wait_ready(1'b1, l1, r1, s1);
        end
        dm_req = 1'b0;
      end
      begin
        int l2, r2, s2;
        if_addr = 32'h300; if_req = 1'b1;
        wait_ready(1'b0, l2, r2, s2);
        if_req = 1'b0;
      end
    join

    mem_hang = 1'b1;
    exp_gnt.push_back('{1'b0, 32'h500, 32'h0});
    exp_dm.push_back(32'hDEADBEEF);
    dm_we = 1'b0; dm_addr = 32'h500; dm_req = 1'b1;
    wait_ready(1'b1, lat, rc, lo);
    dm_req = 1'b0;
    check("timeout_req_cycles", rc, TMO + 1);
    check("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    mem_hang = 1'b0;
    exp_gnt.push_back('{1'b0, 32'h44, 32'h0});
    exp_if.push_back(mem_f(32'h44));
    if_addr = 32'h44; if_req = 1'b1;
    wait_ready(1'b0, lat, rc, lo);
    if_req = 1'b0;
    check("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

    mem_hang = 1'b1;
    exp_gnt.push_back('{1'b0, 32'h600, 32'h0});
    dm_we = 1'b0; dm_addr = 32'h600; dm_req = 1'b1;
    repeat (3) @(posedge Clk); #1;
    check("rst_mid_req_high", {31'd0, mem_req}, 32'd1);
    Rst = 1'b1; dm_req = 1'b0;
    @(posedge Clk); #1;
    check("rst_mid_req_low", {31'd0, mem_req}, 32'd0);
    Rst = 1'b0;
    mem_hang = 1'b0;
    base = ready_seen;
    stray_req++;
    repeat (5) @(posedge Clk); #1;
    check("rst_mid_no_ready", ready_seen, base);
    check("rst_mid_err_clr", {31'd0, timeout_err}, 32'd0);
    check("rst_mid_dm_rdata", dm_rdata, 32'd0);
`ifdef ARB_PERF_CNT_EN
    check("perf_dm_after_rst", perf_dm_cnt, 32'd0);
`endif

    check("gnt_queue_empty", exp_gnt.size(), 32'd0);
    check("if_queue_empty", exp_if.size(), 32'd0);
    check("dm_queue_empty", exp_dm.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
